// File: rtl/nf10_axis_len_checker.sv
// AXI4-Stream length/strobe checker: sums TSTRB bytes per packet and compares with TUSER[15:0] of the first beat.
// Latency: 1 cycle, full throughput (output register + 1-entry skid buffer, registered S_AXIS_TREADY).
// Optional statistics outputs PKT_CNT / ERR_LEN_CNT / ERR_STRB_CNT when NF10_LENCHK_STATS_EN is defined.
module nf10_axis_len_checker #(
  parameter int C_AXIS_TDATA_WIDTH = 256,
  parameter int C_AXIS_TUSER_WIDTH = 128
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [C_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
  input  logic [C_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
  input  logic                            S_AXIS_TLAST,
  input  logic                            S_AXIS_TVALID,
  output logic                            S_AXIS_TREADY,
  output logic [C_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA,
  output logic [C_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB,
  output logic [C_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
  output logic                            M_AXIS_TLAST,
  output logic                            M_AXIS_TVALID,
  input  logic                            M_AXIS_TREADY,
`ifdef NF10_LENCHK_STATS_EN
  output logic [31:0]                     PKT_CNT,
  output logic [31:0]                     ERR_LEN_CNT,
  output logic [31:0]                     ERR_STRB_CNT,
`endif
  output logic                            ERR_LEN,
  output logic                            ERR_STRB
);

  localparam int SW = C_AXIS_TDATA_WIDTH / 8;
  localparam int PW = $clog2(SW + 1);

  typedef struct packed {
    logic [C_AXIS_TDATA_WIDTH-1:0] data;
    logic [SW-1:0]                 strb;
    logic [C_AXIS_TUSER_WIDTH-1:0] user;
    logic                          last;
  } beat_t;

  typedef enum logic {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  function automatic logic [PW-1:0] popcount(input logic [SW-1:0] v);
    logic [PW-1:0] pc;
    pc = '0;
    for (int i = 0; i < SW; i++) pc = pc + PW'(v[i]);
    return pc;
  endfunction

  beat_t  in_beat, out_q, skid_q;
  logic   out_vld, skid_vld, skid_vld_d, in_rdy;
  logic   accept, out_free;
  state_t state, state_d;
  logic [16:0] cnt_q, cnt_base, cnt_sum;
  logic [15:0] len_q, len_sel;
  logic [17:0] sum_wide;
  logic [SW-1:0] strb_inc;
  logic   len_bad, strb_bad;
  logic   err_len_q, err_strb_q;

  assign in_beat  = '{data: S_AXIS_TDATA, strb: S_AXIS_TSTRB, user: S_AXIS_TUSER, last: S_AXIS_TLAST};
  assign accept   = S_AXIS_TVALID && in_rdy;
  assign out_free = !out_vld || M_AXIS_TREADY;

  assign S_AXIS_TREADY = in_rdy;
  assign M_AXIS_TVALID = out_vld;
  assign M_AXIS_TDATA  = out_q.data;
  assign M_AXIS_TSTRB  = out_q.strb;
  assign M_AXIS_TUSER  = out_q.user;
  assign M_AXIS_TLAST  = out_q.last;
  assign ERR_LEN       = err_len_q;
  assign ERR_STRB      = err_strb_q;

  // Skid occupancy next state; ready is its registered inverse so the input never overflows.
  always_comb begin
    skid_vld_d = skid_vld;
    if (skid_vld && out_free)              skid_vld_d = 1'b0;
    else if (!skid_vld && accept && !out_free) skid_vld_d = 1'b1;
  end

  // Output register and skid buffer; skid always drains before new input is taken.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      in_rdy   <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else begin
      in_rdy   <= !skid_vld_d;
      skid_vld <= skid_vld_d;
      if (skid_vld) begin
        if (out_free) begin
          out_q   <= skid_q;
          out_vld <= 1'b1;
        end
      end else if (accept) begin
        if (out_free) begin
          out_q   <= in_beat;
          out_vld <= 1'b1;
        end else begin
          skid_q  <= in_beat;
        end
      end else if (out_free) begin
        out_vld <= 1'b0;
      end
    end
  end

  // Packet-tracking state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state <= IDLE;
    else          state <= state_d;
  end

  // Next state: any accepted beat without TLAST leaves us inside a packet.
  always_comb begin
    state_d = state;
    if (accept) state_d = S_AXIS_TLAST ? IDLE : IN_PKT;
  end

  // Running byte count (saturating), length select and the per-beat checks.
  always_comb begin
    cnt_base = (state == IDLE) ? 17'd0 : cnt_q;
    len_sel  = (state == IDLE) ? S_AXIS_TUSER[15:0] : len_q;
    sum_wide = {1'b0, cnt_base} + 18'(popcount(S_AXIS_TSTRB));
    cnt_sum  = sum_wide[17] ? 17'h1FFFF : sum_wide[16:0];
    len_bad  = (cnt_sum != {1'b0, len_sel});
    strb_inc = S_AXIS_TSTRB + SW'(1);
    strb_bad = (S_AXIS_TSTRB == '0) || ((S_AXIS_TSTRB & strb_inc) != '0) ||
               (!S_AXIS_TLAST && (S_AXIS_TSTRB != '1));
  end

  // Count/length registers and one-cycle error pulses for the beat just accepted.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      cnt_q      <= '0;
      len_q      <= '0;
      err_len_q  <= 1'b0;
      err_strb_q <= 1'b0;
    end else begin
      if (accept) begin
        cnt_q <= cnt_sum;
        len_q <= len_sel;
      end
      err_len_q  <= accept && S_AXIS_TLAST && len_bad;
      err_strb_q <= accept && strb_bad;
    end
  end

`ifdef NF10_LENCHK_STATS_EN
  logic [31:0] pkt_cnt_q, err_len_cnt_q, err_strb_cnt_q;

  assign PKT_CNT      = pkt_cnt_q;
  assign ERR_LEN_CNT  = err_len_cnt_q;
  assign ERR_STRB_CNT = err_strb_cnt_q;

  // Statistics move on the same edge that raises the matching pulse; error counts saturate.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pkt_cnt_q      <= '0;
      err_len_cnt_q  <= '0;
      err_strb_cnt_q <= '0;
    end else begin
      if (accept && S_AXIS_TLAST) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (accept && S_AXIS_TLAST && len_bad && (err_len_cnt_q != '1))
        err_len_cnt_q <= err_len_cnt_q + 32'd1;
      if (accept && strb_bad && (err_strb_cnt_q != '1))
        err_strb_cnt_q <= err_strb_cnt_q + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_nf10_axis_len_checker.sv
// Bench for nf10_axis_len_checker: packet-level model predicts forwarded beats and error pulses.
// Directed packets plus a random-length / random-backpressure run, checked every cycle on the falling edge.
// Stats outputs are checked only when NF10_LENCHK_STATS_EN is defined.
module tb_nf10_axis_len_checker;

  typedef struct packed {
    logic [255:0] d;
    logic [31:0]  s;
    logic [127:0] u;
    logic         l;
  } beat_t;

  logic         ACLK = 1'b0;
  logic         ARESETN = 1'b0;
  logic [255:0] S_AXIS_TDATA = '0;
  logic [31:0]  S_AXIS_TSTRB = '0;
  logic [127:0] S_AXIS_TUSER = '0;
  logic         S_AXIS_TLAST = 1'b0;
  logic         S_AXIS_TVALID = 1'b0;
  logic         S_AXIS_TREADY;
  logic [255:0] M_AXIS_TDATA;
  logic [31:0]  M_AXIS_TSTRB;
  logic [127:0] M_AXIS_TUSER;
  logic         M_AXIS_TLAST;
  logic         M_AXIS_TVALID;
  logic         M_AXIS_TREADY = 1'b0;
  logic         ERR_LEN, ERR_STRB;
`ifdef NF10_LENCHK_STATS_EN
  logic [31:0]  PKT_CNT, ERR_LEN_CNT, ERR_STRB_CNT;
`endif

  nf10_axis_len_checker dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
    .S_AXIS_TLAST(S_AXIS_TLAST), .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY),
    .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
    .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY),
`ifdef NF10_LENCHK_STATS_EN
    .PKT_CNT(PKT_CNT), .ERR_LEN_CNT(ERR_LEN_CNT), .ERR_STRB_CNT(ERR_STRB_CNT),
`endif
    .ERR_LEN(ERR_LEN), .ERR_STRB(ERR_STRB)
  );

  always #5 ACLK = ~ACLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- model state ----------------
  beat_t exp_q[$];
  logic  drv_el = 1'b0, drv_es = 1'b0;      // expected flags of the beat currently driven
  logic  pend_len = 1'b0, pend_strb = 1'b0, pend_last = 1'b0;
  logic  prev_mvld = 1'b0, prev_mrdy = 1'b0, prev_acc = 1'b0;
  beat_t prev_out, prev_in;
  int    seen_err_len = 0, seen_err_strb = 0;
  int    stall_cnt = 0;
  int    mdl_pkt = 0, mdl_elen = 0, mdl_estrb = 0;
  int    mrdy_mode = 0;                      // 0: hold low, 1: hold high, 2: random
  logic [31:0] pkt_strb[$];

  function automatic bit strb_is_bad(input logic [31:0] s, input bit last);
    logic [32:0] ones;
    ones = (33'd1 << $countones(s)) - 33'd1;
    return (s == 32'd0) || ({1'b0, s} != ones) || (!last && s != 32'hFFFF_FFFF);
  endfunction

  // Master ready generator, updated just after each rising edge.
  always @(posedge ACLK) begin
    #1;
    if (mrdy_mode == 2)      M_AXIS_TREADY = ($urandom_range(0, 1) == 1);
    else                     M_AXIS_TREADY = (mrdy_mode == 1);
  end

  // Compare process: every falling edge, check pulses, ordering, stability and latency.
  always @(negedge ACLK) begin
    beat_t cur_out, cur_in;
    logic  acc;
    cur_out = {M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TUSER, M_AXIS_TLAST};
    cur_in  = {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST};
    if (!ARESETN) begin
      chk("rst_m_tvalid", 512'(M_AXIS_TVALID), 512'(0));
      chk("rst_s_tready", 512'(S_AXIS_TREADY), 512'(0));
      chk("rst_err", 512'({ERR_LEN, ERR_STRB}), 512'(0));
      exp_q.delete();
      pend_len = 0; pend_strb = 0; pend_last = 0;
      prev_mvld = 0; prev_mrdy = 0; prev_acc = 0;
      mdl_pkt = 0; mdl_elen = 0; mdl_estrb = 0;
`ifdef NF10_LENCHK_STATS_EN
      chk("rst_stats", 512'({PKT_CNT, ERR_LEN_CNT, ERR_STRB_CNT}), 512'(0));
`endif
    end else begin
      chk("err_len", 512'(ERR_LEN), 512'(pend_len));
      chk("err_strb", 512'(ERR_STRB), 512'(pend_strb));
      if (ERR_LEN)  seen_err_len++;
      if (ERR_STRB) seen_err_strb++;
      if (pend_last) mdl_pkt++;
      if (pend_len)  mdl_elen++;
      if (pend_strb) mdl_estrb++;
`ifdef NF10_LENCHK_STATS_EN
      chk("pkt_cnt", 512'(PKT_CNT), 512'(mdl_pkt));
      chk("err_len_cnt", 512'(ERR_LEN_CNT), 512'(mdl_elen));
      chk("err_strb_cnt", 512'(ERR_STRB_CNT), 512'(mdl_estrb));
`endif
      if (prev_mvld && !prev_mrdy) begin
        chk("hold_valid", 512'(M_AXIS_TVALID), 512'(1));
        chk("hold_payload", 512'(cur_out), 512'(prev_out));
      end
      if (prev_acc && (!prev_mvld || prev_mrdy)) begin
        chk("latency_valid", 512'(M_AXIS_TVALID), 512'(1));
        chk("latency_payload", 512'(cur_out), 512'(prev_in));
      end
      if (M_AXIS_TVALID && M_AXIS_TREADY) begin
        if (exp_q.size() == 0) chk("unexpected_beat", 512'(1), 512'(0));
        else                   chk("out_beat", 512'(cur_out), 512'(exp_q.pop_front()));
      end
      acc = S_AXIS_TVALID && S_AXIS_TREADY;
      if (acc) exp_q.push_back(cur_in);
      pend_len  = acc && drv_el;
      pend_strb = acc && drv_es;
      pend_last = acc && S_AXIS_TLAST;
      prev_acc  = acc;
      prev_in   = cur_in;
      prev_mvld = M_AXIS_TVALID;
      prev_mrdy = M_AXIS_TREADY;
      prev_out  = cur_out;
    end
  end

  // ---------------- driver ----------------
  // Called at posedge+1; returns at posedge+1 right after the beat was taken.
  task automatic drive_beat(input beat_t b, input logic el, input logic es);
    logic acc;
    int   n;
    {S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TUSER, S_AXIS_TLAST} = b;
    drv_el = el; drv_es = es;
    S_AXIS_TVALID = 1'b1;
    n = 0;
    forever begin
      @(negedge ACLK);
      acc = S_AXIS_TREADY;
      @(posedge ACLK); #1;
      if (acc) break;
      stall_cnt++;
      n++;
      if (n > 2000) begin
        chk("accept_timeout", 512'(0), 512'(1));
        break;
      end
    end
  endtask

  task automatic build_strobes(input int len);
    int nb, r;
    pkt_strb.delete();
    nb = (len + 31) / 32;
    for (int i = 0; i < nb - 1; i++) pkt_strb.push_back(32'hFFFF_FFFF);
    r = len - 32 * (nb - 1);
    pkt_strb.push_back((r == 32) ? 32'hFFFF_FFFF : ((32'd1 << r) - 32'd1));
  endtask

  // Packet-level expectations: total strobed bytes (capped) vs length field, strobe rules per beat.
  task automatic send_pkt(input int len_field);
    int    total;
    beat_t b;
    bit    last;
    total = 0;
    foreach (pkt_strb[i]) total += $countones(pkt_strb[i]);
    if (total > 32'h1FFFF) total = 32'h1FFFF;
    foreach (pkt_strb[i]) begin
      last = (i == pkt_strb.size() - 1);
      for (int k = 0; k < 8; k++) b.d[k*32 +: 32] = $urandom;
      b.s = pkt_strb[i];
      b.u = {$urandom, $urandom, $urandom, 16'($urandom), 16'(len_field)};
      b.l = last;
      drive_beat(b, last && (total != len_field), strb_is_bad(pkt_strb[i], last));
    end
    S_AXIS_TVALID = 1'b0;
    drv_el = 1'b0; drv_es = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    forever begin
      @(negedge ACLK); #1;
      if (exp_q.size() == 0 && !M_AXIS_TVALID) break;
      n++;
      if (n > 5000) break;
    end
    chk("drain_empty", 512'(exp_q.size()), 512'(0));
    repeat (2) @(posedge ACLK);
    #1;
  endtask

  initial begin
    int st;
    beat_t b;
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    mrdy_mode = 1;
    @(posedge ACLK); #1;
    chk("ready_after_reset", 512'(S_AXIS_TREADY), 512'(1));

    // 64B, two full beats.
    build_strobes(64); send_pkt(64); drain();
    chk("pkt64_no_err", 512'({32'(seen_err_len), 32'(seen_err_strb)}), 512'(0));

    // 60B with correct then wrong length.
    pkt_strb.delete(); pkt_strb.push_back(32'hFFFF_FFFF); pkt_strb.push_back(32'h0FFF_FFFF);
    send_pkt(60); drain();
    chk("pkt60_no_err", 512'(seen_err_len), 512'(0));
    send_pkt(100); drain();
    chk("pkt60_len100", 512'(seen_err_len), 512'(1));
`ifdef NF10_LENCHK_STATS_EN
    chk("err_len_cnt_lit", 512'(ERR_LEN_CNT), 512'(1));
`endif

    // Short strobe on a non-last beat; length still matches strobed bytes.
    pkt_strb.delete(); pkt_strb.push_back(32'h0000_FFFF);
    pkt_strb.push_back(32'hFFFF_FFFF); pkt_strb.push_back(32'hFFFF_FFFF);
    send_pkt(80); drain();
    chk("strb_short_first", 512'({32'(seen_err_len), 32'(seen_err_strb)}), 512'({32'd1, 32'd1}));

    // Non-contiguous strobe on a last beat, then an empty strobe.
    pkt_strb.delete(); pkt_strb.push_back(32'h00FF_00FF);
    send_pkt(16); drain();
    chk("strb_holes", 512'(seen_err_strb), 512'(2));
    pkt_strb.delete(); pkt_strb.push_back(32'h0000_0000);
    send_pkt(0); drain();
    chk("strb_zero", 512'({32'(seen_err_len), 32'(seen_err_strb)}), 512'({32'd1, 32'd3}));

    // Back-to-back packets at full rate: no stall cycles.
    st = stall_cnt;
    build_strobes(64); send_pkt(64);
    build_strobes(33); send_pkt(33);
    build_strobes(96); send_pkt(96);
    drain();
    chk("b2b_no_stall", 512'(stall_cnt - st), 512'(0));

    // Largest exact length, then a count that saturates.
    build_strobes(65535); send_pkt(65535); drain();
    chk("len_max_ok", 512'(seen_err_len), 512'(1));
    pkt_strb.delete();
    for (int i = 0; i < 4100; i++) pkt_strb.push_back(32'hFFFF_FFFF);
    send_pkt(16'hFFFF); drain();
    chk("cnt_saturate", 512'(seen_err_len), 512'(2));

    // Random lengths under random backpressure.
    mrdy_mode = 2;
    for (int p = 0; p < 1000; p++) begin
      build_strobes($urandom_range(1, 1518));
      send_pkt(pkt_strb.size() == 0 ? 0 : (32 * (pkt_strb.size() - 1) + $countones(pkt_strb[pkt_strb.size() - 1])));
      if ($urandom_range(0, 7) == 0) begin
        @(posedge ACLK); #1;
      end
    end
    mrdy_mode = 1;
    drain();
    chk("random_no_err", 512'({32'(seen_err_len), 32'(seen_err_strb)}), 512'({32'd2, 32'd3}));

    // Reset in the middle of a packet with a beat stuck in the output.
    mrdy_mode = 0;
    @(posedge ACLK); #1;
    for (int k = 0; k < 8; k++) b.d[k*32 +: 32] = $urandom;
    b.s = 32'hFFFF_FFFF; b.u = {112'd0, 16'd96}; b.l = 1'b0;
    drive_beat(b, 1'b0, 1'b0);
    S_AXIS_TVALID = 1'b0;
    @(posedge ACLK); #1;
    chk("pre_reset_held", 512'(M_AXIS_TVALID), 512'(1));
    ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    mrdy_mode = 1;
    @(posedge ACLK); #1;
    build_strobes(64); send_pkt(64); drain();
    chk("post_reset_no_err", 512'({32'(seen_err_len), 32'(seen_err_strb)}), 512'({32'd2, 32'd3}));
`ifdef NF10_LENCHK_STATS_EN
    chk("post_reset_pkt_cnt", 512'(PKT_CNT), 512'(1));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
